// File: rtl/frame_builder.sv
// frame_builder: buffers one payload, then streams preamble, sync word, length,
// payload and CRC-16/CCITT-FALSE (over length + payload) as a byte stream.
module frame_builder #(
  parameter int              SIZE_INPUT_BIT = 8,
  parameter int              PREAMBLE_LEN   = 4,
  parameter logic [7:0]      PREAMBLE_BYTE  = 8'h55,
  parameter logic [15:0]     SYNC_WORD      = 16'h1ACF,
  parameter int              MAX_PAYLOAD    = 255
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [SIZE_INPUT_BIT-1:0] i_data,
  input  logic                      i_valid_input,
  input  logic                      i_last,
  output logic                      o_ready,
  output logic [SIZE_INPUT_BIT-1:0] o_bits,
  output logic                      o_valid_output,
  input  logic                      i_ready,
  output logic                      o_busy,
  output logic                      o_frame_done
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] MAX_LEN  = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    COLLECT,
    PREAMBLE,
    SYNC_HI,
    SYNC_LO,
    LEN,
    PAYLOAD,
    CRC_HI,
    CRC_LO
  } state_t;

  // state_reg names the byte currently presented on o_bits (COLLECT = idle).
  state_t      state_reg, state_next;
  logic [7:0]  bits_reg, bits_next;
  logic        valid_reg, valid_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic [7:0]  count_reg, count_next;
  logic [7:0]  pre_reg, pre_next;
  logic [7:0]  idx_reg, idx_next;
  logic [15:0] crc_reg, crc_next;
  logic [15:0] crc_upd;
  logic [7:0]  rd_data_reg;
  logic        in_hs;
  logic        out_hs;

  // Payload buffer; depth covers the full 8-bit index range.
  logic [7:0]  buf_mem [0:255];

  // One CRC-16 (poly 0x1021, MSB first) step over a whole byte.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  assign o_ready        = (state_reg == COLLECT);
  assign o_bits         = bits_reg;
  assign o_valid_output = valid_reg;
  assign o_busy         = busy_reg;
  assign o_frame_done   = done_reg;

  assign in_hs   = i_valid_input && o_ready;
  assign out_hs  = valid_reg && i_ready;
  assign crc_upd = crc_byte(crc_reg, bits_reg);

  // Buffer write on input handshake; read is registered and addressed with the
  // next index so the following payload byte is always waiting in rd_data_reg.
  always_ff @(posedge i_clk) begin
    if (in_hs) begin
      buf_mem[count_reg] <= i_data;
    end
    rd_data_reg <= buf_mem[idx_next];
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= COLLECT;
      bits_reg  <= 8'h00;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      count_reg <= 8'h00;
      pre_reg   <= 8'h00;
      idx_reg   <= 8'h00;
      crc_reg   <= 16'hFFFF;
    end else begin
      state_reg <= state_next;
      bits_reg  <= bits_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      count_reg <= count_next;
      pre_reg   <= pre_next;
      idx_reg   <= idx_next;
      crc_reg   <= crc_next;
    end
  end

  // Next-state logic: on each output handshake load the following byte.
  always_comb begin
    state_next = state_reg;
    bits_next  = bits_reg;
    valid_next = valid_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    count_next = count_reg;
    pre_next   = pre_reg;
    idx_next   = idx_reg;
    crc_next   = crc_reg;

    case (state_reg)
      COLLECT: begin
        if (in_hs) begin
          count_next = count_reg + 8'd1;
          // A full buffer ends the frame even without i_last.
          if (i_last || (count_reg + 8'd1 == MAX_LEN)) begin
            state_next = PREAMBLE;
            bits_next  = PREAMBLE_BYTE;
            valid_next = 1'b1;
            busy_next  = 1'b1;
            pre_next   = 8'h00;
            idx_next   = 8'h00;
            crc_next   = 16'hFFFF;
          end
        end
      end
      PREAMBLE: begin
        if (out_hs) begin
          if (pre_reg == PRE_LAST) begin
            state_next = SYNC_HI;
            bits_next  = SYNC_WORD[15:8];
          end else begin
            pre_next  = pre_reg + 8'd1;
            bits_next = PREAMBLE_BYTE;
          end
        end
      end
      SYNC_HI: begin
        if (out_hs) begin
          state_next = SYNC_LO;
          bits_next  = SYNC_WORD[7:0];
        end
      end
      SYNC_LO: begin
        if (out_hs) begin
          state_next = LEN;
          bits_next  = count_reg;
        end
      end
      LEN: begin
        if (out_hs) begin
          state_next = PAYLOAD;
          bits_next  = rd_data_reg;
          idx_next   = idx_reg + 8'd1;
          crc_next   = crc_upd;
        end
      end
      PAYLOAD: begin
        // idx_reg is one past the byte on o_bits; equal to count on the last one.
        if (out_hs) begin
          crc_next = crc_upd;
          if (idx_reg == count_reg) begin
            state_next = CRC_HI;
            bits_next  = crc_upd[15:8];
          end else begin
            bits_next = rd_data_reg;
            idx_next  = idx_reg + 8'd1;
          end
        end
      end
      CRC_HI: begin
        if (out_hs) begin
          state_next = CRC_LO;
          bits_next  = crc_reg[7:0];
        end
      end
      CRC_LO: begin
        if (out_hs) begin
          state_next = COLLECT;
          bits_next  = 8'h00;
          valid_next = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          count_next = 8'h00;
          idx_next   = 8'h00;
          crc_next   = 16'hFFFF;
        end
      end
      default: begin
        state_next = COLLECT;
        valid_next = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_builder.sv
// tb_frame_builder: scoreboard bench for frame_builder.
module tb_frame_builder;

  localparam int          PRE_LEN  = 4;
  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [15:0] SYNC     = 16'h1ACF;
  localparam int          MAX_PL   = 255;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;
  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid_input = 1'b0;
  logic       i_last = 1'b0;
  logic       o_ready;
  logic [7:0] o_bits;
  logic       o_valid_output;
  logic       i_ready = 1'b1;
  logic       o_busy;
  logic       o_frame_done;

  int checks = 0;
  int failures = 0;
  int pop_count = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;
  bit rand_en = 1'b0;
  logic ready_level = 1'b1;
  exp_t sb[$];

  always #5 clk = ~clk;

  frame_builder dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_data         (i_data),
    .i_valid_input  (i_valid_input),
    .i_last         (i_last),
    .o_ready        (o_ready),
    .o_bits         (o_bits),
    .o_valid_output (o_valid_output),
    .i_ready        (i_ready),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done)
  );

  // Modulator-side ready: either a fixed level or 50% random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Output monitor: pops the scoreboard on each output handshake.
  bit         exp_done = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] prev_bits = 8'h00;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (o_frame_done !== exp_done) begin
          failures++;
          $display("FAIL frame_done: got %0b expected %0b", o_frame_done, exp_done);
        end
        exp_done = 1'b0;
        if (stall_prev) begin
          checks++;
          if (o_valid_output !== 1'b1 || o_bits !== prev_bits) begin
            failures++;
            $display("FAIL stall_hold: got valid=%0b bits=%02h expected valid=1 bits=%02h",
                     o_valid_output, o_bits, prev_bits);
          end
        end
        if (o_valid_output === 1'b1) begin
          checks++;
          if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_while_emit: got o_ready=%0b expected 0", o_ready);
          end
        end
        if (o_valid_output === 1'b1 && i_ready === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL extra_byte: got %02h expected no output", o_bits);
          end else begin
            e = sb.pop_front();
            pop_count++;
            if (o_bits !== e.b) begin
              failures++;
              $display("FAIL stream_byte #%0d: got %02h expected %02h", pop_count, o_bits, e.b);
            end
            if (e.last) exp_done = 1'b1;
          end
        end
        stall_prev = (o_valid_output === 1'b1) && (i_ready !== 1'b1);
        prev_bits  = o_bits;
      end else begin
        exp_done   = 1'b0;
        stall_prev = 1'b0;
      end
      if (o_frame_done === 1'b1) done_cnt++;
    end
  end

  // Reference CRC: bit-serial LFSR form.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [15:0] crc_calc(input byte_q_t q);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) c = crc_step(c, q[i]);
    return c;
  endfunction

  task automatic push_one(input logic [7:0] b, input logic l);
    exp_t e;
    e.b = b;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic push_frame(input byte_q_t pl);
    byte_q_t covered;
    logic [15:0] c;
    covered = pl;
    covered.push_front(8'(pl.size()));
    c = crc_calc(covered);
    for (int i = 0; i < PRE_LEN; i++) push_one(PRE_BYTE, 1'b0);
    push_one(SYNC[15:8], 1'b0);
    push_one(SYNC[7:0], 1'b0);
    push_one(8'(pl.size()), 1'b0);
    foreach (pl[i]) push_one(pl[i], 1'b0);
    push_one(c[15:8], 1'b0);
    push_one(c[7:0], 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
    int c;
    ok = 1'b0;
    c = 0;
    i_data = d;
    i_valid_input = 1'b1;
    i_last = l;
    while (!ok && c < 3000) begin
      @(negedge clk);
      if (o_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
      c++;
    end
    i_valid_input = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t pl, input bit with_last, output bit ok);
    bit b_ok;
    ok = 1'b1;
    foreach (pl[i]) begin
      send_byte(pl[i], with_last && (i == pl.size() - 1), b_ok);
      ok = ok && b_ok;
    end
  endtask

  task automatic drain(input int budget, output bit ok);
    int c;
    ok = 1'b0;
    c = 0;
    while (!ok && c < budget) begin
      @(negedge clk);
      if (sb.size() == 0 && o_valid_output !== 1'b1) ok = 1'b1;
      c++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b expected 1", o_ready); end
    if (o_valid_output !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", o_valid_output); end
    if (o_bits !== 8'h00) begin failures++; $display("FAIL reset_bits: got %02h expected 00", o_bits); end
    if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", o_busy); end
    if (o_frame_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", o_frame_done); end
    @(posedge clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic test_single();
    byte_q_t pl;
    bit ok;
    pl = '{8'h00};
    send_frame(pl, 1'b1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_send: got timeout expected accept"); end
    push_frame(pl);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks += 2;
      if (o_valid_output !== 1'b1) begin
        failures++;
        $display("FAIL single_nobubble cycle %0d: got valid=%0b expected 1", i, o_valid_output);
      end
      if (o_busy !== 1'b1) begin
        failures++;
        $display("FAIL single_busy cycle %0d: got %0b expected 1", i, o_busy);
      end
    end
    @(negedge clk);
    checks += 3;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL single_done_ready: got %0b expected 1", o_ready); end
    if (o_busy !== 1'b0) begin failures++; $display("FAIL single_done_busy: got %0b expected 0", o_busy); end
    if (o_valid_output !== 1'b0) begin failures++; $display("FAIL single_done_valid: got %0b expected 0", o_valid_output); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_crc_nine();
    byte_q_t pl;
    bit ok;
    logic [15:0] c;
    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c = crc_calc(pl);
    checks++;
    if (c !== 16'h29B1) begin failures++; $display("FAIL crc_model_check: got %04h expected 29b1", c); end
    send_frame(pl, 1'b1, ok);
    push_frame(pl);
    drain(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL crc_nine_drain: got timeout expected empty"); end
  endtask

  task automatic test_backpressure();
    byte_q_t pl;
    bit ok;
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom_range(0, 255)));
    rand_en = 1'b1;
    send_frame(pl, 1'b1, ok);
    push_frame(pl);
    drain(2000, ok);
    rand_en = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL backpressure_drain: got timeout expected empty"); end
  endtask

  task automatic test_max_payload();
    byte_q_t pl;
    byte_q_t pl2;
    bit ok;
    for (int i = 0; i < MAX_PL; i++) pl.push_back(8'(i) ^ 8'h3C);
    send_frame(pl, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL max_send: got timeout expected accept"); end
    push_frame(pl);
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0) begin failures++; $display("FAIL max_ready_drop: got %0b expected 0", o_ready); end
    @(posedge clk);
    #1;
    pl2 = '{8'hA5};
    send_frame(pl2, 1'b1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL max_next_send: got timeout expected accept"); end
    push_frame(pl2);
    drain(1000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL max_drain: got timeout expected empty"); end
  endtask

  task automatic test_reset_mid();
    byte_q_t pl;
    byte_q_t pl3;
    bit ok;
    int start;
    int c;
    for (int i = 0; i < 10; i++) pl.push_back(8'hC0 + 8'(i));
    start = pop_count;
    send_frame(pl, 1'b1, ok);
    push_frame(pl);
    c = 0;
    while (pop_count < start + PRE_LEN + 6 && c < 200) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (pop_count < start + PRE_LEN + 6) begin
      failures++;
      $display("FAIL reset_mid_reach: got %0d bytes expected %0d", pop_count - start, PRE_LEN + 6);
    end
    mon_en = 1'b0;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    checks += 3;
    if (o_valid_output !== 1'b0) begin failures++; $display("FAIL reset_mid_valid: got %0b expected 0", o_valid_output); end
    if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_mid_ready: got %0b expected 1", o_ready); end
    if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy: got %0b expected 0", o_busy); end
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    mon_en = 1'b1;
    pl3 = '{8'h11, 8'h22, 8'h33};
    send_frame(pl3, 1'b1, ok);
    push_frame(pl3);
    drain(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_mid_drain: got timeout expected empty"); end
  endtask

  task automatic test_back_to_back();
    byte_q_t pa;
    byte_q_t pb;
    bit ok;
    int d0;
    pa = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    pb = '{8'hF0, 8'hE1, 8'hD2};
    send_frame(pa, 1'b1, ok);
    push_frame(pa);
    d0 = done_cnt;
    send_byte(pb[0], 1'b0, ok);
    checks++;
    if (done_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL b2b_accept_after_done: got done_cnt=%0d expected %0d", done_cnt, d0 + 1);
    end
    send_byte(pb[1], 1'b0, ok);
    send_byte(pb[2], 1'b1, ok);
    push_frame(pb);
    @(negedge clk);
    checks += 2;
    if (o_valid_output !== 1'b1) begin failures++; $display("FAIL b2b_preamble_valid: got %0b expected 1", o_valid_output); end
    if (o_bits !== PRE_BYTE) begin failures++; $display("FAIL b2b_preamble_bits: got %02h expected %02h", o_bits, PRE_BYTE); end
    drain(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_drain: got timeout expected empty"); end
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_single();
    test_crc_nine();
    test_backpressure();
    test_max_payload();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
